edge_irq_scheduler: RTL

- Sticky negative-edge capture on WIDTH input lines, combined with a scheduler that serves pending events one at a time to a single consumer.
- Each captured event is presented over a valid/ready handshake as a line ID, in round-robin order across unmasked pending lines.
- Sits between raw status/interrupt lines and the single event consumer (CPU IRQ stub or sequencer).

---
 rtl/edge_irq_scheduler.sv | 93 +++++++++
 1 files changed

// File: rtl/edge_irq_scheduler.sv
// Sticky falling-edge capture with round-robin service of pending lines, one event at a time.
// Edge to evt_valid_o takes 2 cycles; evt_id_o holds while evt_ready_i is low, and at least 2 cycles per event.
module edge_irq_scheduler #(
  parameter int WIDTH = 32,
  parameter int IDW   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic             evt_valid_o,
  output logic [IDW-1:0]   evt_id_o,
  input  logic             evt_ready_i,
  output logic [WIDTH-1:0] pending_o,
  output logic [WIDTH-1:0] overrun_o,
  output logic             busy_o
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q, pending, overrun;
  logic [WIDTH-1:0] edge_det, eligible, ack_mask, pending_nxt, overrun_nxt;
  logic [IDW-1:0]   rr_ptr, id_q, winner;
  logic             found, hs;

  assign edge_det = data_q & ~data_i;
  assign eligible = pending & ~mask_i;
  assign hs       = (state == PRESENT) && evt_ready_i;
  assign ack_mask = hs ? (WIDTH'(1) << id_q) : '0;

  // A new edge always wins over any clear landing in the same cycle.
  assign pending_nxt = edge_det | (pending & ~(clr_i | ack_mask));
  assign overrun_nxt = (edge_det & pending) | (overrun & ~clr_i);

  // First eligible line at or above rr_ptr, wrapping at WIDTH-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int             k;
      logic [IDW-1:0] kidx;
      k = int'(rr_ptr) + i;
      if (k >= WIDTH) k = k - WIDTH;
      kidx = IDW'(k);
      if (!found && eligible[kidx]) begin
        found  = 1'b1;
        winner = kidx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = PRESENT;
      PRESENT: if (evt_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt_valid_o = (state == PRESENT);
    busy_o      = (state == PRESENT);
    evt_id_o    = id_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      pending <= '0;
      overrun <= '0;
      rr_ptr  <= '0;
      id_q    <= '0;
    end else begin
      data_q  <= data_i;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
      if (state == IDLE && found) id_q <= winner;
      if (hs) rr_ptr <= (id_q == IDW'(WIDTH - 1)) ? '0 : id_q + IDW'(1);
    end
  end

  assign pending_o = pending;
  assign overrun_o = overrun;

endmodule
